// File: rtl/if_stage.sv
// OTTER instruction-fetch stage: next-PC selection, instruction memory read
// control and the IF/ID slot with stall hold and redirect squash.
module if_stage #(
   parameter int XLEN    = 32,
   parameter bit HOLD_EN = 1'b1
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [XLEN-1:0] PC_COUNT,
   output logic [XLEN-1:0] PC_DIN,
   output logic            PC_WRITE,
   output logic [XLEN-1:0] IMEM_ADDR,
   output logic            IMEM_RDEN,
   input  logic [XLEN-1:0] IMEM_DOUT,
   input  logic            ID_STALL,
   input  logic            BR_TAKEN,
   input  logic [XLEN-1:0] BR_TARGET,
   output logic [XLEN-1:0] IF_ID_PC,
   output logic [XLEN-1:0] IF_ID_PC4,
   output logic [XLEN-1:0] IF_ID_INSTR,
   output logic            IF_ID_VALID,
   output logic            IF_ID_MISALIGN
);

   localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

   typedef enum logic [1:0] {
      SLOT_EMPTY = 2'b00,
      SLOT_LIVE  = 2'b01,
      SLOT_HELD  = 2'b10
   } slot_state_t;

   slot_state_t     slot_state_reg, slot_state_next;
   logic [XLEN-1:0] if_id_pc_reg, if_id_pc_next;
   logic [XLEN-1:0] if_id_pc4_reg, if_id_pc4_next;
   logic            misalign_reg, misalign_next;
   logic [XLEN-1:0] hold_reg, hold_next;
   logic [XLEN-1:0] pc_plus4;
   logic            pc_aligned;

   assign pc_plus4   = PC_COUNT + XLEN'(4);
   assign pc_aligned = (PC_COUNT[1:0] == 2'b00);

   // Fetch control is a function of PC, stall and redirect only, never of IMEM_DOUT.
   assign PC_DIN    = BR_TAKEN ? BR_TARGET : pc_plus4;
   assign PC_WRITE  = BR_TAKEN | ~ID_STALL;
   assign IMEM_ADDR = PC_COUNT;
   assign IMEM_RDEN = ~ID_STALL & ~BR_TAKEN & pc_aligned & RST_N;

   always_comb begin
      slot_state_next = slot_state_reg;
      if_id_pc_next   = if_id_pc_reg;
      if_id_pc4_next  = if_id_pc4_reg;
      misalign_next   = misalign_reg;
      hold_next       = hold_reg;
      if (BR_TAKEN) begin
         slot_state_next = SLOT_EMPTY;
         hold_next       = '0;
      end else if (ID_STALL) begin
         // Memory output is only trustworthy on the first stalled edge.
         if (slot_state_reg == SLOT_LIVE) begin
            slot_state_next = HOLD_EN ? SLOT_HELD : SLOT_LIVE;
            hold_next       = IMEM_DOUT;
         end
      end else begin
         slot_state_next = SLOT_LIVE;
         if_id_pc_next   = PC_COUNT;
         if_id_pc4_next  = pc_plus4;
         misalign_next   = ~pc_aligned;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         slot_state_reg <= SLOT_EMPTY;
         if_id_pc_reg   <= '0;
         if_id_pc4_reg  <= XLEN'(4);
         misalign_reg   <= 1'b0;
      end else begin
         slot_state_reg <= slot_state_next;
         if_id_pc_reg   <= if_id_pc_next;
         if_id_pc4_reg  <= if_id_pc4_next;
         misalign_reg   <= misalign_next;
      end
   end

   generate
      if (HOLD_EN) begin : g_hold
         always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
               hold_reg <= '0;
            end else begin
               hold_reg <= hold_next;
            end
         end
      end else begin : g_no_hold
         assign hold_reg = '0;
      end
   endgenerate

   // A misaligned slot never issued a read, so its instruction is a NOP.
   always_comb begin
      IF_ID_VALID = 1'b0;
      IF_ID_INSTR = NOP_INSTR;
      case (slot_state_reg)
         SLOT_LIVE: begin
            IF_ID_VALID = 1'b1;
            IF_ID_INSTR = misalign_reg ? NOP_INSTR : IMEM_DOUT;
         end
         SLOT_HELD: begin
            IF_ID_VALID = 1'b1;
            if (misalign_reg) begin
               IF_ID_INSTR = NOP_INSTR;
            end else begin
               IF_ID_INSTR = HOLD_EN ? hold_reg : IMEM_DOUT;
            end
         end
         default: begin
            IF_ID_VALID = 1'b0;
            IF_ID_INSTR = NOP_INSTR;
         end
      endcase
   end

   assign IF_ID_PC       = if_id_pc_reg;
   assign IF_ID_PC4      = if_id_pc4_reg;
   assign IF_ID_MISALIGN = misalign_reg;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: upstream PC register, a synchronous instruction memory
// whose output is garbage after an unread edge, and a slot scoreboard.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] instr;
      logic        valid;
      logic        mis;
      logic        full;
   } slot_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc_count;
   logic [31:0] pc_din;
   logic        pc_write;
   logic [31:0] imem_addr;
   logic        imem_rden;
   logic [31:0] imem_dout;
   logic        id_stall = 1'b0;
   logic        br_taken = 1'b0;
   logic [31:0] br_target = '0;
   logic [31:0] if_id_pc, if_id_pc4, if_id_instr;
   logic        if_id_valid, if_id_misalign;

   int    n_checks = 0;
   int    n_pass = 0;
   slot_t exp_q[$];
   slot_t exp_cur;

   if_stage #(.XLEN(32), .HOLD_EN(1'b1)) dut (
      .CLK            (clk),
      .RST_N          (rst_n),
      .PC_COUNT       (pc_count),
      .PC_DIN         (pc_din),
      .PC_WRITE       (pc_write),
      .IMEM_ADDR      (imem_addr),
      .IMEM_RDEN      (imem_rden),
      .IMEM_DOUT      (imem_dout),
      .ID_STALL       (id_stall),
      .BR_TAKEN       (br_taken),
      .BR_TARGET      (br_target),
      .IF_ID_PC       (if_id_pc),
      .IF_ID_PC4      (if_id_pc4),
      .IF_ID_INSTR    (if_id_instr),
      .IF_ID_VALID    (if_id_valid),
      .IF_ID_MISALIGN (if_id_misalign)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_val(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h0010_0113;
      return {a[15:0] ^ 16'h5A00, ~a[15:0]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_count <= '0;
      else if (pc_write) pc_count <= pc_din;
   end

   always @(posedge clk) begin
      if (imem_rden) imem_dout <= imem_val(imem_addr);
      else imem_dout <= $urandom | 32'h8000_0001;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no_finish, need finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h, need %08h", tag, got, exp);
   endtask

   task automatic compare_slot(input slot_t e);
      check("valid", {31'b0, if_id_valid}, {31'b0, e.valid});
      check("instr", if_id_instr, e.instr);
      if (e.full) begin
         check("if_id_pc", if_id_pc, e.pc);
         check("if_id_pc4", if_id_pc4, e.pc4);
         check("misalign", {31'b0, if_id_misalign}, {31'b0, e.mis});
      end
      $display("slot pc=%08h instr=%08h valid=%0b mis=%0b", if_id_pc, if_id_instr,
               if_id_valid, if_id_misalign);
   endtask

   task automatic pop_compare();
      if (exp_q.size() > 0) compare_slot(exp_q.pop_front());
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic cycle(input logic stall, input logic br, input logic [31:0] tgt);
      slot_t nxt;
      logic  mis;
      pop_compare();
      id_stall  = stall;
      br_taken  = br;
      br_target = tgt;
      #1;
      mis = (pc_count[1:0] != 2'b00);
      check("pc_din", pc_din, br ? tgt : pc_count + 32'd4);
      check("pc_write", {31'b0, pc_write}, {31'b0, br | ~stall});
      check("imem_rden", {31'b0, imem_rden}, {31'b0, ~stall & ~br & ~mis});
      check("imem_addr", imem_addr, pc_count);
      if (br) begin
         nxt = '{pc: 32'h0, pc4: 32'h0, instr: NOP, valid: 1'b0, mis: 1'b0, full: 1'b0};
      end else if (stall) begin
         nxt = exp_cur;
      end else begin
         nxt = '{pc: pc_count, pc4: pc_count + 32'd4, instr: mis ? NOP : imem_val(pc_count),
                 valid: 1'b1, mis: mis, full: 1'b1};
      end
      exp_cur = nxt;
      exp_q.push_back(nxt);
      $display("drive pc_count=%08h stall=%0b br=%0b tgt=%08h", pc_count, stall, br, tgt);
      @(negedge clk);
   endtask

   initial begin
      exp_cur = '{pc: 32'h0, pc4: 32'h4, instr: NOP, valid: 1'b0, mis: 1'b0, full: 1'b1};
      repeat (2) @(negedge clk);
      compare_slot(exp_cur);
      check("rden_in_reset", {31'b0, imem_rden}, 32'h0);
      exp_q.push_back(exp_cur);
      rst_n = 1'b1;

      // Sequential fetch of 0, 4, 8, then stall with 8 in ID.
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      repeat (3) cycle(1'b1, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      // PC_COUNT is now 0x10: redirect to 0x100.
      cycle(1'b0, 1'b1, 32'h100);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      // Stall, then redirect while still stalled.
      cycle(1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 32'h200);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      // Misaligned target.
      cycle(1'b0, 1'b1, 32'h102);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      // Wrap-around at the top of the address space.
      cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      // Back-to-back redirects.
      cycle(1'b0, 1'b1, 32'h40);
      cycle(1'b0, 1'b1, 32'h80);
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 40; i++) begin
         cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
               {22'b0, 8'($urandom_range(0, 255)), 2'b00});
      end
      // Asynchronous reset in the middle of a stall.
      cycle(1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 32'h0);
      cycle(1'b1, 1'b0, 32'h0);
      pop_compare();
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      compare_slot('{pc: 32'h0, pc4: 32'h4, instr: NOP, valid: 1'b0, mis: 1'b0, full: 1'b1});
      check("rst_rden", {31'b0, imem_rden}, 32'h0);
      check("rst_pc_write", {31'b0, pc_write}, 32'h0);
      check("rst_pc_din", pc_din, 32'h4);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
